// File: rtl/tmds_pkg.sv
// TMDS token constants and word-level decode helpers shared by the
// transmit encoder and the receive decoder.
package tmds_pkg;

    localparam logic [9:0] CTRL_TOK_00 = 10'h354;
    localparam logic [9:0] CTRL_TOK_01 = 10'h0AB;
    localparam logic [9:0] CTRL_TOK_10 = 10'h154;
    localparam logic [9:0] CTRL_TOK_11 = 10'h2AB;

    typedef enum logic {SEARCH, LOCKED} align_state_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] c;
    } ctrl_dec_t;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] c;
        logic       de;
    } tmds_out_t;

    // q[9] undoes the DC-balance inversion, q[8] selects XOR vs XNOR chaining
    function automatic logic [7:0] tmds_decode_data(input logic [9:0] q);
        logic [7:0] m;
        logic [7:0] d;
        m    = q[9] ? ~q[7:0] : q[7:0];
        d[0] = m[0];
        for (int i = 1; i < 8; i++)
            d[i] = q[8] ? (m[i] ^ m[i-1]) : ~(m[i] ^ m[i-1]);
        return d;
    endfunction

    function automatic ctrl_dec_t tmds_is_ctrl(input logic [9:0] q);
        ctrl_dec_t r;
        r = '0;
        case (q)
            CTRL_TOK_00: r = '{hit: 1'b1, c: 2'b00};
            CTRL_TOK_01: r = '{hit: 1'b1, c: 2'b01};
            CTRL_TOK_10: r = '{hit: 1'b1, c: 2'b10};
            CTRL_TOK_11: r = '{hit: 1'b1, c: 2'b11};
            default:     r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// Word-boundary recovery: 20-bit window barrel select plus the search/lock
// machine that slips the bit offset until control-token runs appear.
module tmds_word_aligner
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS  = 8,
    parameter int SEARCH_WORDS = 2048,
    parameter int LOCK_TIMEOUT = 1048576
) (
    input  logic       clk_pixel,
    input  logic       rst,
    input  logic [9:0] i_word,
    input  logic       i_valid,
    input  logic       i_resync,
    output logic [9:0] o_aligned,
    output logic       o_locked,
    output logic [3:0] o_offset
);

    // run counter must be able to hold LOCK_TOKENS itself
    localparam int RUN_W = $clog2(LOCK_TOKENS + 1);
    localparam int SW_W  = $clog2(SEARCH_WORDS);
    localparam int LT_W  = $clog2(LOCK_TIMEOUT);
    localparam int WC_W  = (SW_W > LT_W) ? SW_W : LT_W;

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_TOKENS);
    localparam logic [WC_W-1:0]  SLIP_AT = WC_W'(SEARCH_WORDS - 1);
    localparam logic [WC_W-1:0]  TMO_AT  = WC_W'(LOCK_TIMEOUT - 1);

    align_state_e     state;
    logic [9:0]       prev;
    logic [3:0]       offset;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_nxt;
    logic [1:0]       last_c;
    logic [WC_W-1:0]  wcnt;
    logic             skip;
    logic [19:0]      shifted;
    ctrl_dec_t        ctrl;
    logic             run_hit;

    always_comb begin
        shifted   = {i_word, prev} >> offset;
        o_aligned = shifted[9:0];
        ctrl      = tmds_is_ctrl(o_aligned);
        run_nxt   = '0;
        if (ctrl.hit) begin
            if (run != '0 && ctrl.c == last_c)
                run_nxt = (run == RUN_MAX) ? run : run + RUN_W'(1);
            else
                run_nxt = RUN_W'(1);
        end
        run_hit = !skip && (run_nxt == RUN_MAX);
    end

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            prev   <= '0;
            state  <= SEARCH;
            offset <= '0;
            run    <= '0;
            last_c <= '0;
            wcnt   <= '0;
            skip   <= 1'b0;
        end else begin
            if (i_valid)
                prev <= i_word;
            if (i_resync) begin
                state  <= SEARCH;
                offset <= '0;
                run    <= '0;
                last_c <= '0;
                wcnt   <= '0;
                skip   <= 1'b0;
            end else if (i_valid) begin
                skip <= 1'b0;
                // the beat right after a slip mixes old and new alignment
                if (!skip) begin
                    run <= run_nxt;
                    if (ctrl.hit)
                        last_c <= ctrl.c;
                end
                case (state)
                    SEARCH: begin
                        if (run_hit) begin
                            state <= LOCKED;
                            wcnt  <= '0;
                        end else if (wcnt == SLIP_AT) begin
                            offset <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                            run    <= '0;
                            wcnt   <= '0;
                            skip   <= 1'b1;
                        end else begin
                            wcnt <= wcnt + WC_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (run_hit) begin
                            wcnt <= '0;
                        end else if (wcnt == TMO_AT) begin
                            state <= SEARCH;
                            wcnt  <= '0;
                        end else begin
                            wcnt <= wcnt + WC_W'(1);
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

    assign o_locked = (state == LOCKED);
    assign o_offset = offset;

endmodule

// File: rtl/tmds_rx_decoder.sv
// Single-lane TMDS receive decoder: aligns deserialized words, then decodes
// them into pixel data or control bits over a two-stage pipeline.
module tmds_rx_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS  = 8,
    parameter int SEARCH_WORDS = 2048,
    parameter int LOCK_TIMEOUT = 1048576
) (
    input  logic       clk_pixel,
    input  logic       rst,
    input  logic [9:0] i_word,
    input  logic       i_valid,
    input  logic       i_resync,
    output logic [7:0] o_data,
    output logic [1:0] o_c,
    output logic       o_de,
    output logic       o_valid,
    output logic       o_locked,
    output logic [3:0] o_offset
);

    localparam int STAGES = 2;

    logic [STAGES:0] vld_pipe;
    logic [STAGES:1] vld_q;
    logic [9:0]      aligned;
    logic [9:0]      s1_word;
    ctrl_dec_t       s1_ctrl;
    tmds_out_t       dec_q;

    tmds_word_aligner #(
        .LOCK_TOKENS  (LOCK_TOKENS),
        .SEARCH_WORDS (SEARCH_WORDS),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_align (
        .clk_pixel (clk_pixel),
        .rst       (rst),
        .i_word    (i_word),
        .i_valid   (i_valid),
        .i_resync  (i_resync),
        .o_aligned (aligned),
        .o_locked  (o_locked),
        .o_offset  (o_offset)
    );

    assign vld_pipe = {vld_q, i_valid};
    assign s1_ctrl  = tmds_is_ctrl(s1_word);

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            vld_q   <= '0;
            s1_word <= '0;
            dec_q   <= '0;
        end else begin
            vld_q <= vld_pipe[STAGES-1:0];
            if (vld_pipe[0])
                s1_word <= aligned;
            // o_c is sticky across data periods
            if (vld_pipe[1]) begin
                if (s1_ctrl.hit) begin
                    dec_q.data <= '0;
                    dec_q.c    <= s1_ctrl.c;
                    dec_q.de   <= 1'b0;
                end else begin
                    dec_q.data <= tmds_decode_data(s1_word);
                    dec_q.de   <= 1'b1;
                end
            end
        end
    end

    assign o_data  = dec_q.data;
    assign o_c     = dec_q.c;
    assign o_de    = dec_q.de;
    assign o_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Randomized bench for tmds_rx_decoder against a beat-level reference model.
module tb_tmds_rx_decoder;

    localparam int LT = 8;
    localparam int SW = 16;
    localparam int TO = 64;

    logic       clk_pixel = 1'b0;
    logic       rst;
    logic [9:0] i_word;
    logic       i_valid;
    logic       i_resync;
    logic [7:0] o_data;
    logic [1:0] o_c;
    logic       o_de;
    logic       o_valid;
    logic       o_locked;
    logic [3:0] o_offset;

    tmds_rx_decoder #(.LOCK_TOKENS(LT), .SEARCH_WORDS(SW), .LOCK_TIMEOUT(TO)) dut (
        .clk_pixel (clk_pixel),
        .rst       (rst),
        .i_word    (i_word),
        .i_valid   (i_valid),
        .i_resync  (i_resync),
        .o_data    (o_data),
        .o_c       (o_c),
        .o_de      (o_de),
        .o_valid   (o_valid),
        .o_locked  (o_locked),
        .o_offset  (o_offset)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        int         due;
        logic [7:0] d;
        logic [1:0] c;
        logic       de;
    } exp_t;

    exp_t       expq[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [9:0] m_prev;
    int         m_off, m_run, m_tok, m_wcnt, m_lastc;
    bit         m_locked, m_skip;
    logic [7:0] h_d;
    logic [1:0] h_c;
    logic       h_de;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
        end
    endtask

    // token value 0..3 or -1 for a data word
    function automatic int tok_of(input logic [9:0] q);
        case (q)
            10'h354: return 0;
            10'h0AB: return 1;
            10'h154: return 2;
            10'h2AB: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] q);
        logic [7:0] m;
        logic [7:0] d;
        m = q[9] ? ~q[7:0] : q[7:0];
        d = '0;
        d[0] = m[0];
        for (int i = 1; i < 8; i++)
            d[i] = (m[i] ^ m[i-1]) ^ ~q[8];
        return d;
    endfunction

    function automatic logic [9:0] rotl(input logic [9:0] t, input int n);
        logic [19:0] x;
        x = {t, t} << n;
        return x[19:10];
    endfunction

    function automatic logic [9:0] rnd_data();
        logic [9:0] w;
        w = 10'($urandom);
        if (tok_of(w) >= 0) w = w ^ 10'h001;
        return w;
    endfunction

    function automatic logic [9:0] tok_word(input int t);
        logic [9:0] tbl [4];
        tbl[0] = 10'h354; tbl[1] = 10'h0AB; tbl[2] = 10'h154; tbl[3] = 10'h2AB;
        return tbl[t];
    endfunction

    task automatic model_clear();
        m_locked = 0; m_off = 0; m_run = 0; m_tok = 0; m_wcnt = 0; m_skip = 0;
    endtask

    // Beat-level reference: what the decoder commits at this edge.
    task automatic model_edge(input bit v, input logic [9:0] w, input bit rs);
        logic [19:0] win;
        logic [9:0]  a;
        int          t;
        bit          hit;
        exp_t        e;
        if (v) begin
            win = {w, m_prev};
            a = 10'(win >> m_off);
            m_prev = w;
            t = tok_of(a);
            e.due = cyc + 1;
            if (t >= 0) begin
                m_lastc = t;
                e.d = 8'h00; e.c = 2'(t); e.de = 1'b0;
            end else begin
                e.d = ref_decode(a); e.c = 2'(m_lastc); e.de = 1'b1;
            end
            expq.push_back(e);
        end else begin
            t = -1;
        end
        if (rs) begin
            model_clear();
        end else if (v) begin
            if (!m_skip) begin
                if (t < 0) m_run = 0;
                else if (m_run > 0 && t == m_tok) m_run = (m_run < LT) ? m_run + 1 : LT;
                else m_run = 1;
                if (t >= 0) m_tok = t;
            end
            hit = !m_skip && (m_run == LT);
            m_skip = 0;
            if (!m_locked) begin
                if (hit) begin
                    m_locked = 1; m_wcnt = 0;
                end else if (m_wcnt == SW - 1) begin
                    m_off = (m_off + 1) % 10; m_run = 0; m_wcnt = 0; m_skip = 1;
                end else m_wcnt++;
            end else begin
                if (hit) m_wcnt = 0;
                else if (m_wcnt == TO - 1) begin
                    m_locked = 0; m_wcnt = 0;
                end else m_wcnt++;
            end
        end
    endtask

    task automatic step(input bit v, input logic [9:0] w, input bit rs);
        i_valid = v; i_word = w; i_resync = rs;
        @(posedge clk_pixel);
        cyc++;
        model_edge(v, w, rs);
        #1;
        if (expq.size() > 0 && expq[0].due == cyc) begin
            chk("valid", 32'(o_valid), 32'd1);
            chk("data", 32'(o_data), 32'(expq[0].d));
            chk("c", 32'(o_c), 32'(expq[0].c));
            chk("de", 32'(o_de), 32'(expq[0].de));
            h_d = expq[0].d; h_c = expq[0].c; h_de = expq[0].de;
            void'(expq.pop_front());
        end else begin
            chk("idle_valid", 32'(o_valid), 32'd0);
            chk("hold_data", 32'(o_data), 32'(h_d));
            chk("hold_c", 32'(o_c), 32'(h_c));
            chk("hold_de", 32'(o_de), 32'(h_de));
        end
        chk("locked", 32'(o_locked), 32'(m_locked));
        chk("offset", 32'(o_offset), 32'(m_off));
    endtask

    // beat with an occasional idle cycle in front of it
    task automatic beat(input logic [9:0] w);
        if ($urandom_range(0, 3) == 0) step(1'b0, 10'($urandom), 1'b0);
        step(1'b1, w, 1'b0);
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_word = '0; i_resync = 1'b0;
        repeat (3) @(posedge clk_pixel);
        #1;
        rst = 1'b0;
        m_prev = '0; m_lastc = 0; model_clear();
        h_d = '0; h_c = '0; h_de = 1'b0;
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_c", 32'(o_c), 32'd0);
        chk("rst_de", 32'(o_de), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_locked", 32'(o_locked), 32'd0);
        chk("rst_offset", 32'(o_offset), 32'd0);

        // aligned stream of c=00 tokens
        repeat (12) beat(10'h354);
        chk("lock_off0", 32'(o_locked), 32'd1);

        // data branches, then refresh lock
        beat(10'h100); beat(10'h2FF); beat(10'h1FF);
        repeat (20) beat(rnd_data());
        repeat (8) beat(10'h354);

        for (int t = 1; t < 4; t++) repeat (8) beat(tok_word(t));
        chk("lock_tokcycle", 32'(o_locked), 32'd1);

        // timeout on a long data period
        repeat (70) beat(rnd_data());
        chk("timeout_unlock", 32'(o_locked), 32'd0);

        // misaligned stream: slips to offset 3 and locks
        step(1'b0, 10'h000, 1'b1);
        repeat (3 * SW + 20) beat(rotl(10'h354, 3));
        chk("lock_off3", 32'(o_offset), 32'd3);
        chk("lock_off3_l", 32'(o_locked), 32'd1);

        step(1'b0, 10'h000, 1'b1);
        repeat (5 * SW + 20) beat(rotl(10'h354, 5));
        chk("lock_off5", 32'(o_offset), 32'd5);
        step(1'b0, 10'h000, 1'b1);
        chk("resync_unlock", 32'(o_locked), 32'd0);
        chk("resync_off", 32'(o_offset), 32'd0);

        // resync coincident with a slip
        for (int i = 0; i < 2 * SW && m_wcnt != SW - 1; i++) beat(rnd_data());
        chk("pre_slip_cnt", 32'(m_wcnt), 32'(SW - 1));
        step(1'b1, rnd_data(), 1'b1);
        chk("slip_resync_off", 32'(o_offset), 32'd0);

        // walk the offset through the 9 -> 0 wrap
        repeat (10 * SW + 5) beat(rnd_data());

        // random mix of token runs, data bursts and rare resyncs
        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = $urandom_range(0, 19);
            if (kind == 0) step(1'b1, rnd_data(), 1'b1);
            else if (kind < 10) begin
                int t;
                t = $urandom_range(0, 3);
                repeat ($urandom_range(1, 12)) beat(rotl(tok_word(t), 0));
            end else repeat ($urandom_range(1, 10)) beat(rnd_data());
        end

        // drain the pipeline
        repeat (4) step(1'b0, 10'h000, 1'b0);
        chk("drained", 32'(expq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
